hline_setup: RTL and testbench

- Front-end setup stage for the hline z-buffer walker; sits directly upstream of it.
- Takes raw span endpoints (x1, x2, y, z1, z2) and surface base addresses.
- Computes the walker's precomputed operands with a sequential divider, then issues a one-cycle start to the walker and waits for it to finish.
- Removes the dx/slope/rem/err computation from software.

---
 rtl/hline_setup.sv | 220 ++++++++++++++++++++++
 tb/tb_hline_setup.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hline_setup.sv
// Setup stage for the hline z-buffer walker: orders the span endpoints, derives
// dx, slope, remainder and initial error with a 32-step restoring divider,
// forms the framebuffer / z-buffer start addresses, then starts the walker and
// waits for it to report completion.
module hline_setup #(
  parameter int unsigned STRIDE_LOG2 = 12,
  parameter int unsigned XW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x1,
  input  logic [XW-1:0] x2,
  input  logic [XW-1:0] y,
  input  logic [31:0]   z1,
  input  logic [31:0]   z2,
  input  logic [31:0]   fb_base,
  input  logic [31:0]   zbuff_base,
  input  logic          line_done,
  output logic          busy,
  output logic          done,
  output logic          line_start,
  output logic [31:0]   dx,
  output logic [31:0]   slope,
  output logic [31:0]   rem,
  output logic [31:0]   err,
  output logic [31:0]   z_start,
  output logic [31:0]   fb_addr,
  output logic [31:0]   zbuff_addr
);

  typedef enum logic [2:0] {
    StIdle,
    StOrder,
    StDivide,
    StAdjust,
    StIssue,
    StWaitLine,
    StFinish
  } state_e;

  state_e state_q, state_d;

  // Captured request
  logic [XW-1:0] x1_q, x1_d, x2_q, x2_d, y_q, y_d;
  logic [31:0]   z1_q, z1_d, z2_q, z2_d, fb_base_q, fb_base_d, zb_base_q, zb_base_d;

  // Divider state; quo_q starts as |dz| and is shifted out as quotient bits shift in
  logic [31:0]   quo_q, quo_d;
  logic [32:0]   prem_q, prem_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          neg_q, neg_d;

  // Operand outputs
  logic [31:0]   dx_q, dx_d, slope_q, slope_d, rem_q, rem_d, err_q, err_d;
  logic [31:0]   z_start_q, z_start_d, fb_addr_q, fb_addr_d, zb_addr_q, zb_addr_d;

  // Endpoint ordering and derived values
  logic [XW-1:0] xl, xr, dx_n;
  logic [31:0]   zl, zr, dz_mag, row_off, col_off;
  logic [32:0]   dz;
  logic          dz_neg;
  logic [32:0]   trial;

  // Order endpoints so the span runs left to right; dz sign/magnitude from the ordered pair
  always_comb begin
    xl      = x1_q;
    xr      = x2_q;
    zl      = z1_q;
    zr      = z2_q;
    if (x1_q > x2_q) begin
      xl = x2_q;
      xr = x1_q;
      zl = z2_q;
      zr = z1_q;
    end
    dx_n    = xr - xl;
    dz      = {1'b0, zr} - {1'b0, zl};
    dz_neg  = dz[32];
    dz_mag  = dz_neg ? (32'd0 - dz[31:0]) : dz[31:0];
    row_off = 32'(y_q) << STRIDE_LOG2;
    col_off = 32'(xl) << 2;
    trial   = {prem_q[31:0], quo_q[31]};
  end

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    y_d       = y_q;
    z1_d      = z1_q;
    z2_d      = z2_q;
    fb_base_d = fb_base_q;
    zb_base_d = zb_base_q;
    quo_d     = quo_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    dx_d      = dx_q;
    slope_d   = slope_q;
    rem_d     = rem_q;
    err_d     = err_q;
    z_start_d = z_start_q;
    fb_addr_d = fb_addr_q;
    zb_addr_d = zb_addr_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          x1_d      = x1;
          x2_d      = x2;
          y_d       = y;
          z1_d      = z1;
          z2_d      = z2;
          fb_base_d = fb_base;
          zb_base_d = zbuff_base;
          state_d   = StOrder;
        end
      end
      StOrder: begin
        dx_d      = 32'(dx_n);
        z_start_d = zl;
        fb_addr_d = fb_base_q + row_off + col_off;
        zb_addr_d = zb_base_q + row_off + col_off;
        quo_d     = dz_mag;
        neg_d     = dz_neg;
        prem_d    = '0;
        cnt_d     = '0;
        state_d   = (dx_n != '0) ? StDivide : StAdjust;
      end
      StDivide: begin
        // One restoring step: bring down the next dividend bit, subtract if it fits
        if (trial >= {1'b0, dx_q}) begin
          prem_d = trial - {1'b0, dx_q};
          quo_d  = {quo_q[30:0], 1'b1};
        end else begin
          prem_d = trial;
          quo_d  = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = StAdjust;
      end
      StAdjust: begin
        err_d = dx_q >> 1;
        if (dx_q == '0) begin
          slope_d = '0;
          rem_d   = '0;
        end else begin
          rem_d = prem_q[31:0];
          // Quotients that do not fit a signed 32-bit value clamp symmetrically
          if (quo_q[31]) slope_d = neg_q ? 32'h8000_0001 : 32'h7FFF_FFFF;
          else           slope_d = neg_q ? (32'd0 - quo_q) : quo_q;
        end
        state_d = StIssue;
      end
      StIssue:    state_d = StWaitLine;
      StWaitLine: if (line_done) state_d = StFinish;
      StFinish:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      x1_q      <= '0;
      x2_q      <= '0;
      y_q       <= '0;
      z1_q      <= '0;
      z2_q      <= '0;
      fb_base_q <= '0;
      zb_base_q <= '0;
      quo_q     <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      dx_q      <= '0;
      slope_q   <= '0;
      rem_q     <= '0;
      err_q     <= '0;
      z_start_q <= '0;
      fb_addr_q <= '0;
      zb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y_q       <= y_d;
      z1_q      <= z1_d;
      z2_q      <= z2_d;
      fb_base_q <= fb_base_d;
      zb_base_q <= zb_base_d;
      quo_q     <= quo_d;
      prem_q    <= prem_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      dx_q      <= dx_d;
      slope_q   <= slope_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      z_start_q <= z_start_d;
      fb_addr_q <= fb_addr_d;
      zb_addr_q <= zb_addr_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFinish);
  assign line_start = (state_q == StIssue);
  assign dx         = dx_q;
  assign slope      = slope_q;
  assign rem        = rem_q;
  assign err        = err_q;
  assign z_start    = z_start_q;
  assign fb_addr    = fb_addr_q;
  assign zbuff_addr = zb_addr_q;

endmodule

// File: tb/tb_hline_setup.sv
// Directed bench for hline_setup: a vector table of spans with hand-computed
// operands and latencies, plus sequences for ignored starts and mid-divide reset.
module tb_hline_setup;

  logic        clk = 1'b0;
  logic        reset, start, line_done;
  logic [15:0] x1, x2, y;
  logic [31:0] z1, z2, fb_base, zbuff_base;
  logic        busy, done, line_start;
  logic [31:0] dx, slope, rem, err, z_start, fb_addr, zbuff_addr;

  hline_setup #(.STRIDE_LOG2(12), .XW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x1         (x1),
    .x2         (x2),
    .y          (y),
    .z1         (z1),
    .z2         (z2),
    .fb_base    (fb_base),
    .zbuff_base (zbuff_base),
    .line_done  (line_done),
    .busy       (busy),
    .done       (done),
    .line_start (line_start),
    .dx         (dx),
    .slope      (slope),
    .rem        (rem),
    .err        (err),
    .z_start    (z_start),
    .fb_addr    (fb_addr),
    .zbuff_addr (zbuff_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x1, x2, y;
    logic [31:0] z1, z2, fb, zb;
    logic [31:0] e_dx, e_slope, e_rem, e_err, e_zs, e_fb, e_zb;
    int          e_lat;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request during cycle T; returns positioned at cycle T+1
  task automatic drive_start(input vec_t v);
    x1 = v.x1; x2 = v.x2; y = v.y; z1 = v.z1; z2 = v.z2;
    fb_base = v.fb; zbuff_base = v.zb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_ops(input string tag, input vec_t v);
    chk({tag, " dx"}, dx, v.e_dx);
    chk({tag, " slope"}, slope, v.e_slope);
    chk({tag, " rem"}, rem, v.e_rem);
    chk({tag, " err"}, err, v.e_err);
    chk({tag, " z_start"}, z_start, v.e_zs);
    chk({tag, " fb_addr"}, fb_addr, v.e_fb);
    chk({tag, " zbuff_addr"}, zbuff_addr, v.e_zb);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " line_start"}, 32'(line_start), 32'd0);
    chk({tag, " dx"}, dx, 32'd0);
    chk({tag, " slope"}, slope, 32'd0);
    chk({tag, " rem"}, rem, 32'd0);
    chk({tag, " err"}, err, 32'd0);
    chk({tag, " z_start"}, z_start, 32'd0);
    chk({tag, " fb_addr"}, fb_addr, 32'd0);
    chk({tag, " zbuff_addr"}, zbuff_addr, 32'd0);
  endtask

  // One full transaction; line_done is raised ld_gap cycles after line_start
  task automatic run_vec(input int i, input int ld_gap);
    vec_t  v;
    int    cyc;
    string tag;
    v   = vecs[i];
    tag = $sformatf("v%0d", i);
    drive_start(v);
    cyc = 1;
    while (line_start !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({tag, " line_start latency"}, 32'(cyc), 32'(v.e_lat));
    chk_ops(tag, v);
    tick();
    cyc++;
    chk({tag, " line_start single"}, 32'(line_start), 32'd0);
    while (cyc < v.e_lat + ld_gap) begin
      chk({tag, " no early done"}, 32'(done), 32'd0);
      tick();
      cyc++;
    end
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    tick();
    chk({tag, " done single"}, 32'(done), 32'd0);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " dx held"}, dx, v.e_dx);
    chk({tag, " slope held"}, slope, v.e_slope);
  endtask

  initial begin
    int   ls_cnt, ls_cyc, done_cyc;
    logic busy44, busy45;
    vec_t alt;

    //          x1    x2  y   z1            z2            fb            zb
    //          dx    slope         rem     err    z_start       fb_addr       zbuff_addr   lat
    vecs[0] = '{16'd10, 16'd20, 16'd2, 32'd100, 32'd135, 32'h1000_0000, 32'h2000_0000,
                32'd10, 32'd3, 32'd5, 32'd5, 32'd100, 32'h1000_2028, 32'h2000_2028, 35};
    vecs[1] = '{16'd20, 16'd10, 16'd2, 32'd135, 32'd100, 32'h1000_0000, 32'h2000_0000,
                32'd10, 32'd3, 32'd5, 32'd5, 32'd100, 32'h1000_2028, 32'h2000_2028, 35};
    vecs[2] = '{16'd0, 16'd4, 16'd0, 32'd100, 32'd90, 32'h1000_0000, 32'h2000_0000,
                32'd4, 32'hFFFF_FFFE, 32'd2, 32'd2, 32'd100, 32'h1000_0000, 32'h2000_0000, 35};
    vecs[3] = '{16'd7, 16'd7, 16'd3, 32'd50, 32'd80, 32'h1000_0000, 32'h2000_0000,
                32'd0, 32'd0, 32'd0, 32'd0, 32'd50, 32'h1000_301C, 32'h2000_301C, 3};
    vecs[4] = '{16'd0, 16'd1, 16'd0, 32'd0, 32'hFFFF_FFFF, 32'h1000_0000, 32'h2000_0000,
                32'd1, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h1000_0000, 32'h2000_0000, 35};
    vecs[5] = '{16'd0, 16'd1, 16'd0, 32'hFFFF_FFFF, 32'd0, 32'h1000_0000, 32'h2000_0000,
                32'd1, 32'h8000_0001, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h1000_0000,
                32'h2000_0000, 35};
    vecs[6] = '{16'd8, 16'd9, 16'd1, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h0000_0000,
                32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0000_1010, 32'h0000_1020, 35};
    vecs[7] = '{16'd100, 16'd3, 16'd5, 32'd7, 32'd1000, 32'h1000_0000, 32'h2000_0000,
                32'd97, 32'hFFFF_FFF6, 32'd23, 32'd48, 32'd1000, 32'h1000_500C,
                32'h2000_500C, 35};

    reset = 1'b1; start = 1'b0; line_done = 1'b0;
    x1 = '0; x2 = '0; y = '0; z1 = '0; z2 = '0; fb_base = '0; zbuff_base = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_zero("reset");

    for (int i = 0; i < NV; i++) run_vec(i, 5);

    // Extra starts mid-divide, in WAIT_LINE and at FINISH must all be ignored;
    // line_done during ISSUE must not be seen.
    alt = vecs[0];
    alt.x1 = 16'd0;
    alt.z2 = 32'd5000;
    drive_start(vecs[0]);
    ls_cnt = 0; ls_cyc = 0; done_cyc = 0; busy44 = 1'b1; busy45 = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (line_start === 1'b1) begin ls_cnt++; ls_cyc = c; end
      if (done === 1'b1) done_cyc = c;
      if (c == 44) busy44 = busy;
      if (c == 45) busy45 = busy;
      start = 1'b0;
      line_done = 1'b0;
      if (c == 10) begin
        x1 = alt.x1; z2 = alt.z2; start = 1'b1;
      end
      if (c == 35) line_done = 1'b1;
      if (c == 38) start = 1'b1;
      if (c == 42) line_done = 1'b1;
      if (c == 43) start = 1'b1;
      tick();
    end
    start = 1'b0;
    line_done = 1'b0;
    chk("hs line_start count", 32'(ls_cnt), 32'd1);
    chk("hs line_start cycle", 32'(ls_cyc), 32'd35);
    chk("hs done cycle", 32'(done_cyc), 32'd43);
    chk("hs start at finish busy", 32'(busy44), 32'd0);
    chk("hs idle after finish", 32'(busy45), 32'd0);
    chk_ops("hs", vecs[0]);

    // Reset during DIVIDE aborts the span with no further pulses
    drive_start(vecs[2]);
    for (int c = 1; c < 20; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("midreset");
    ls_cnt = 0; done_cyc = 0;
    for (int c = 0; c < 40; c++) begin
      if (line_start === 1'b1) ls_cnt++;
      if (done === 1'b1) done_cyc++;
      tick();
    end
    chk("midreset no line_start", 32'(ls_cnt), 32'd0);
    chk("midreset no done", 32'(done_cyc), 32'd0);
    run_vec(2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
